// File: rtl/imm_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_if
// Handshake/bus bundle for the pipelined immediate generator.
//
// Signals
//   in_valid_i  / in_ready_o   : instruction-side valid/ready
//   inst_i      [31:0]         : instruction word
//   tag_i       [TAG_W-1:0]    : sideband (PC/ROB tag) travelling with inst
//   out_valid_o / out_ready_i  : result-side valid/ready
//   imm_o       [XLEN-1:0]     : extended immediate
//   fmt_o       [2:0]          : format code
//   illegal_o                  : opcode not recognised
//   tag_o       [TAG_W-1:0]    : sideband out
//
// Modports
//   master : the environment (drives instructions, consumes results)
//   slave  : the immediate generator itself
// -----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       inst_i;
  logic [TAG_W-1:0]  tag_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [XLEN-1:0]   imm_o;
  logic [2:0]        fmt_o;
  logic              illegal_o;
  logic [TAG_W-1:0]  tag_o;

  modport master (
    output in_valid_i, inst_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
  );

  modport slave (
    input  in_valid_i, inst_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, tag_o
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined immediate generator for the decode stage. One instruction per
// cycle is decoded into an XLEN-wide immediate, a format code and an
// illegal-opcode flag, then held in a 2-entry skid buffer whose head entry
// drives every output directly from flops.
//
// Parameters
//   XLEN  : 32 or 64, datapath width
//   TAG_W : width of the sideband carried unchanged with each instruction
//
// Ports
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   flush_i  : synchronous flush, empties the buffer (beats accept/drain)
//   bus      : imm_gen_pipe_if.slave (input handshake, output handshake)
//
// Compile-time option
//   IMM_GEN_CSR_EN : when defined, SYSTEM instructions are decoded (CSR
//                    address as I-format, uimm as Z-format). When undefined,
//                    SYSTEM is reported illegal and fmt Z never appears.
//
// Format codes: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 Z
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  imm_gen_pipe_if.slave    bus
);

  // Opcodes
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // Format codes
  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
`ifdef IMM_GEN_CSR_EN
  localparam logic [2:0] FMT_Z     = 3'd7;
`endif

  // Buffer entry layout: {tag, illegal, fmt, imm}
  localparam int DEC_W = XLEN + 4;
  localparam int ENT_W = TAG_W + DEC_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Decode one instruction into {illegal, fmt, imm}. All immediates are built
  // at 64 bits and truncated, so the same expressions serve both XLEN values.
  function automatic logic [DEC_W-1:0] decode(input logic [31:0] inst);
    logic [63:0] v_imm;
    logic [2:0]  v_fmt;
    logic        v_ill;
    logic [63:0] v_i;
    logic [63:0] v_s;
    logic [63:0] v_b;
    logic [63:0] v_u;
    logic [63:0] v_j;
    logic [2:0]  v_f3;
    logic        v_is_shift;

    v_i = {{52{inst[31]}}, inst[31:20]};
    v_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    v_b = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    v_u = {{32{inst[31]}}, inst[31:12], 12'h000};
    v_j = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    v_f3       = inst[14:12];
    v_is_shift = (v_f3 == 3'b001) || (v_f3 == 3'b101);

    v_imm = 64'h0;
    v_fmt = FMT_NONE;
    v_ill = 1'b0;

    case (inst[6:0])
      OPC_OP_IMM: begin
        if (v_is_shift) begin
          v_fmt = FMT_SHAMT;
          // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one
          if (XLEN == 64) begin
            v_imm = {58'h0, inst[25:20]};
          end else begin
            v_imm = {59'h0, inst[24:20]};
          end
        end else begin
          v_fmt = FMT_I;
          v_imm = v_i;
        end
      end
      OPC_LOAD, OPC_JALR: begin
        v_fmt = FMT_I;
        v_imm = v_i;
      end
      OPC_STORE: begin
        v_fmt = FMT_S;
        v_imm = v_s;
      end
      OPC_BRANCH: begin
        v_fmt = FMT_B;
        v_imm = v_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        v_fmt = FMT_U;
        v_imm = v_u;
      end
      OPC_JAL: begin
        v_fmt = FMT_J;
        v_imm = v_j;
      end
      OPC_OP: begin
        v_fmt = FMT_NONE;
        v_imm = 64'h0;
      end
      OPC_OP_IMM_32: begin
        // Word-sized ops exist only on RV64; their shamt is always 5 bits
        if (XLEN == 64) begin
          if (v_is_shift) begin
            v_fmt = FMT_SHAMT;
            v_imm = {59'h0, inst[24:20]};
          end else begin
            v_fmt = FMT_I;
            v_imm = v_i;
          end
        end else begin
          v_ill = 1'b1;
        end
      end
      OPC_OP_32: begin
        if (XLEN == 64) begin
          v_fmt = FMT_NONE;
        end else begin
          v_ill = 1'b1;
        end
      end
      OPC_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
        case (v_f3)
          3'b101, 3'b110, 3'b111: begin
            v_fmt = FMT_Z;
            v_imm = {59'h0, inst[19:15]};
          end
          3'b001, 3'b010, 3'b011: begin
            v_fmt = FMT_I;
            v_imm = v_i;
          end
          3'b000: begin
            v_fmt = FMT_NONE;
          end
          default: begin
            v_ill = 1'b1;
          end
        endcase
`else
        v_ill = 1'b1;
`endif
      end
      default: begin
        v_ill = 1'b1;
      end
    endcase

    return {v_ill, v_fmt, v_imm[XLEN-1:0]};
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ENT_W-1:0]   r_head;
  logic [ENT_W-1:0]   r_skid;
  logic               r_out_valid;
  logic               r_in_ready;

  logic               w_accept;
  logic               w_drain;
  logic [ENT_W-1:0]   w_new_entry;
  logic               w_load_head_new;
  logic               w_load_head_skid;
  logic               w_load_skid;

  assign w_accept    = bus.in_valid_i & r_in_ready;
  assign w_drain     = r_out_valid & bus.out_ready_i;
  assign w_new_entry = {bus.tag_i, decode(bus.inst_i)};

  // Buffer occupancy register; valid/ready flags are registered copies of
  // the next occupancy so neither depends combinationally on out_ready_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_FULL);
    end
  end

  // Next occupancy from accept/drain; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_drain) begin
            w_state_nxt = ST_FULL;
          end else if (w_drain && !w_accept) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            w_state_nxt = ST_ONE;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Entry load strobes: where the decoded word goes and when the skid
  // entry moves up to the head.
  always_comb begin
    w_load_head_new  = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush_i) begin
      w_load_head_new  = 1'b0;
      w_load_head_skid = 1'b0;
      w_load_skid      = 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          w_load_head_new = w_accept;
        end
        ST_ONE: begin
          // Simultaneous accept and drain replaces the head in place
          w_load_head_new = w_accept & w_drain;
          w_load_skid     = w_accept & ~w_drain;
        end
        ST_FULL: begin
          w_load_head_skid = w_drain;
        end
        default: begin
          w_load_head_new  = 1'b0;
          w_load_head_skid = 1'b0;
          w_load_skid      = 1'b0;
        end
      endcase
    end
  end

  // Entry storage; the head holds its contents whenever it is not loaded,
  // which keeps the outputs stable under back-pressure.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_head_new) begin
        r_head <= w_new_entry;
      end else if (w_load_head_skid) begin
        r_head <= r_skid;
      end else begin
        r_head <= r_head;
      end
      if (w_load_skid) begin
        r_skid <= w_new_entry;
      end else begin
        r_skid <= r_skid;
      end
    end
  end

  assign bus.in_ready_o  = r_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.imm_o       = r_head[XLEN-1:0];
  assign bus.fmt_o       = r_head[XLEN+2:XLEN];
  assign bus.illegal_o   = r_head[XLEN+3];
  assign bus.tag_o       = r_head[ENT_W-1:DEC_W];

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic clk;
  logic rst_n;
  logic flush;

  int n_tests = 0;
  int n_fail  = 0;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (bus32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus32.in_valid_i  = 1'b0;
    bus32.inst_i      = 32'h0;
    bus32.tag_i       = 32'h0;
    bus32.out_ready_i = 1'b1;
    bus64.in_valid_i  = 1'b0;
    bus64.inst_i      = 32'h0;
    bus64.tag_i       = 32'h0;
    bus64.out_ready_i = 1'b1;
    flush             = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (bus32.out_valid_o !== 1'b0 || bus32.in_ready_o !== 1'b1 ||
        bus32.imm_o !== 32'h0 || bus32.fmt_o !== 3'd0 ||
        bus32.illegal_o !== 1'b0 || bus32.tag_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset32: v=%b r=%b imm=%h fmt=%0d ill=%b tag=%h, need 0 1 0 0 0 0",
               bus32.out_valid_o, bus32.in_ready_o, bus32.imm_o, bus32.fmt_o,
               bus32.illegal_o, bus32.tag_o);
    end
    n_tests++;
    if (bus64.out_valid_o !== 1'b0 || bus64.in_ready_o !== 1'b1 ||
        bus64.imm_o !== 64'h0 || bus64.fmt_o !== 3'd0 ||
        bus64.illegal_o !== 1'b0 || bus64.tag_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset64: v=%b r=%b imm=%h fmt=%0d ill=%b tag=%h, need 0 1 0 0 0 0",
               bus64.out_valid_o, bus64.in_ready_o, bus64.imm_o, bus64.fmt_o,
               bus64.illegal_o, bus64.tag_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Back-to-back decode at XLEN=32; each result checked one cycle after accept
  task automatic test_decode32();
    logic [31:0] v_inst [13];
    logic [31:0] v_imm  [13];
    logic [2:0]  v_fmt  [13];
    logic        v_ill  [13];
    v_inst[0]  = 32'hFFF00093; v_imm[0]  = 32'hFFFFFFFF; v_fmt[0]  = 3'd1; v_ill[0]  = 1'b0; // addi
    v_inst[1]  = 32'hFE112E23; v_imm[1]  = 32'hFFFFFFFC; v_fmt[1]  = 3'd2; v_ill[1]  = 1'b0; // sw
    v_inst[2]  = 32'hFE000CE3; v_imm[2]  = 32'hFFFFFFF8; v_fmt[2]  = 3'd3; v_ill[2]  = 1'b0; // beq
    v_inst[3]  = 32'h00509093; v_imm[3]  = 32'h00000005; v_fmt[3]  = 3'd6; v_ill[3]  = 1'b0; // slli
    v_inst[4]  = 32'h40505093; v_imm[4]  = 32'h00000005; v_fmt[4]  = 3'd6; v_ill[4]  = 1'b0; // srai
    v_inst[5]  = 32'h800000B7; v_imm[5]  = 32'h80000000; v_fmt[5]  = 3'd4; v_ill[5]  = 1'b0; // lui
    v_inst[6]  = 32'h12345017; v_imm[6]  = 32'h12345000; v_fmt[6]  = 3'd4; v_ill[6]  = 1'b0; // auipc
    v_inst[7]  = 32'h0080006F; v_imm[7]  = 32'h00000008; v_fmt[7]  = 3'd5; v_ill[7]  = 1'b0; // jal
    v_inst[8]  = 32'h00C08067; v_imm[8]  = 32'h0000000C; v_fmt[8]  = 3'd1; v_ill[8]  = 1'b0; // jalr
    v_inst[9]  = 32'h00000033; v_imm[9]  = 32'h00000000; v_fmt[9]  = 3'd0; v_ill[9]  = 1'b0; // add
    v_inst[10] = 32'h0000007F; v_imm[10] = 32'h00000000; v_fmt[10] = 3'd0; v_ill[10] = 1'b1; // unknown
    v_inst[11] = 32'hFFF0009B; v_imm[11] = 32'h00000000; v_fmt[11] = 3'd0; v_ill[11] = 1'b1; // addiw on RV32
`ifdef IMM_GEN_CSR_EN
    v_inst[12] = 32'h0052D073; v_imm[12] = 32'h00000005; v_fmt[12] = 3'd7; v_ill[12] = 1'b0; // csrrwi
`else
    v_inst[12] = 32'h0052D073; v_imm[12] = 32'h00000000; v_fmt[12] = 3'd0; v_ill[12] = 1'b1; // csrrwi
`endif
    bus32.out_ready_i = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus32.in_valid_i = 1'b1;
      bus32.inst_i     = v_inst[i];
      bus32.tag_i      = 32'h100 + i;
      tick();
      n_tests++;
      if (bus32.out_valid_o !== 1'b1 || bus32.imm_o !== v_imm[i] ||
          bus32.fmt_o !== v_fmt[i] || bus32.illegal_o !== v_ill[i] ||
          bus32.tag_o !== (32'h100 + i)) begin
        n_fail++;
        $display("FAIL decode32[%0d] inst=%h: v=%b imm=%h fmt=%0d ill=%b tag=%h, need 1 %h %0d %b %h",
                 i, v_inst[i], bus32.out_valid_o, bus32.imm_o, bus32.fmt_o,
                 bus32.illegal_o, bus32.tag_o, v_imm[i], v_fmt[i], v_ill[i], 32'h100 + i);
      end
    end
    bus32.in_valid_i = 1'b0;
    tick();
    n_tests++;
    if (bus32.out_valid_o !== 1'b0 || bus32.in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL decode32_drained: v=%b r=%b, need 0 1", bus32.out_valid_o, bus32.in_ready_o);
    end
  endtask

  task automatic test_decode64();
    logic [31:0] v_inst [6];
    logic [63:0] v_imm  [6];
    logic [2:0]  v_fmt  [6];
    v_inst[0] = 32'h800000B7; v_imm[0] = 64'hFFFFFFFF80000000; v_fmt[0] = 3'd4; // lui
    v_inst[1] = 32'h0080006F; v_imm[1] = 64'h0000000000000008; v_fmt[1] = 3'd5; // jal
    v_inst[2] = 32'h03F09093; v_imm[2] = 64'h000000000000003F; v_fmt[2] = 3'd6; // slli 63
    v_inst[3] = 32'h03F0909B; v_imm[3] = 64'h000000000000001F; v_fmt[3] = 3'd6; // slliw 5-bit
    v_inst[4] = 32'hFFF0009B; v_imm[4] = 64'hFFFFFFFFFFFFFFFF; v_fmt[4] = 3'd1; // addiw
    v_inst[5] = 32'h0000003B; v_imm[5] = 64'h0000000000000000; v_fmt[5] = 3'd0; // addw
    bus64.out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus64.in_valid_i = 1'b1;
      bus64.inst_i     = v_inst[i];
      bus64.tag_i      = 32'h200 + i;
      tick();
      n_tests++;
      if (bus64.out_valid_o !== 1'b1 || bus64.imm_o !== v_imm[i] ||
          bus64.fmt_o !== v_fmt[i] || bus64.illegal_o !== 1'b0 ||
          bus64.tag_o !== (32'h200 + i)) begin
        n_fail++;
        $display("FAIL decode64[%0d] inst=%h: v=%b imm=%h fmt=%0d ill=%b tag=%h, need 1 %h %0d 0 %h",
                 i, v_inst[i], bus64.out_valid_o, bus64.imm_o, bus64.fmt_o,
                 bus64.illegal_o, bus64.tag_o, v_imm[i], v_fmt[i], 32'h200 + i);
      end
    end
    bus64.in_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_back_pressure();
    logic [31:0] v_inst [3];
    logic [31:0] v_imm  [3];
    logic [2:0]  v_fmt  [3];
    logic [31:0] v_tag  [3];
    int n_sent;
    int n_recv;
    int idx;
    logic w_acc;
    logic w_drn;
    v_inst[0] = 32'hFFF00093; v_imm[0] = 32'hFFFFFFFF; v_fmt[0] = 3'd1; v_tag[0] = 32'hA0;
    v_inst[1] = 32'hFE112E23; v_imm[1] = 32'hFFFFFFFC; v_fmt[1] = 3'd2; v_tag[1] = 32'hB1;
    v_inst[2] = 32'hFE000CE3; v_imm[2] = 32'hFFFFFFF8; v_fmt[2] = 3'd3; v_tag[2] = 32'hC2;
    n_sent = 0;
    n_recv = 0;
    bus32.out_ready_i = 1'b0;
    // Stalled: offer back-to-back, at most two may be taken
    for (int c = 0; c < 5; c++) begin
      idx = (n_sent < 3) ? n_sent : 2;
      bus32.in_valid_i = 1'b1;
      bus32.inst_i     = v_inst[idx];
      bus32.tag_i      = v_tag[idx];
      w_acc = bus32.in_ready_o;
      tick();
      if (w_acc) n_sent++;
      n_tests++;
      if (bus32.out_valid_o !== 1'b1 || bus32.imm_o !== v_imm[0] ||
          bus32.fmt_o !== v_fmt[0] || bus32.tag_o !== v_tag[0]) begin
        n_fail++;
        $display("FAIL stall_hold c=%0d: v=%b imm=%h fmt=%0d tag=%h, need 1 %h %0d %h",
                 c, bus32.out_valid_o, bus32.imm_o, bus32.fmt_o, bus32.tag_o,
                 v_imm[0], v_fmt[0], v_tag[0]);
      end
      if (n_sent == 2) begin
        n_tests++;
        if (bus32.in_ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_ready c=%0d: in_ready=%b, need 0", c, bus32.in_ready_o);
        end
      end
    end
    n_tests++;
    if (n_sent != 2) begin
      n_fail++;
      $display("FAIL stall_accepts: accepted=%0d, need 2", n_sent);
    end
    // Release: everything must emerge in order
    bus32.out_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      idx = (n_sent < 3) ? n_sent : 2;
      bus32.in_valid_i = (n_sent < 3);
      bus32.inst_i     = v_inst[idx];
      bus32.tag_i      = v_tag[idx];
      w_acc = bus32.in_valid_i & bus32.in_ready_o;
      w_drn = bus32.out_valid_o;
      if (w_drn) begin
        idx = (n_recv < 3) ? n_recv : 2;
        n_tests++;
        if (n_recv >= 3 || bus32.imm_o !== v_imm[idx] ||
            bus32.fmt_o !== v_fmt[idx] || bus32.tag_o !== v_tag[idx]) begin
          n_fail++;
          $display("FAIL drain_order[%0d]: imm=%h fmt=%0d tag=%h, need %h %0d %h",
                   n_recv, bus32.imm_o, bus32.fmt_o, bus32.tag_o,
                   v_imm[idx], v_fmt[idx], v_tag[idx]);
        end
        n_recv++;
      end
      tick();
      if (w_acc) n_sent++;
    end
    n_tests++;
    if (n_recv != 3 || n_sent != 3) begin
      n_fail++;
      $display("FAIL drain_count: sent=%0d recv=%0d, need 3 3", n_sent, n_recv);
    end
    bus32.in_valid_i = 1'b0;
  endtask

  task automatic fill_two();
    bus32.out_ready_i = 1'b0;
    bus32.in_valid_i  = 1'b1;
    bus32.inst_i      = 32'hFFF00093;
    bus32.tag_i       = 32'h55;
    tick();
    bus32.inst_i      = 32'hFE112E23;
    bus32.tag_i       = 32'h66;
    tick();
    bus32.in_valid_i  = 1'b0;
    n_tests++;
    if (bus32.out_valid_o !== 1'b1 || bus32.in_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_two: v=%b r=%b, need 1 0", bus32.out_valid_o, bus32.in_ready_o);
    end
  endtask

  task automatic test_flush();
    fill_two();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (bus32.out_valid_o !== 1'b0 || bus32.in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: v=%b r=%b, need 0 1", bus32.out_valid_o, bus32.in_ready_o);
    end
    // Instruction offered alongside flush is dropped
    bus32.out_ready_i = 1'b1;
    bus32.in_valid_i  = 1'b1;
    bus32.inst_i      = 32'h0080006F;
    flush             = 1'b1;
    tick();
    flush             = 1'b0;
    bus32.in_valid_i  = 1'b0;
    n_tests++;
    if (bus32.out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop: out_valid=%b, need 0", bus32.out_valid_o);
    end
    tick();
    n_tests++;
    if (bus32.out_valid_o !== 1'b0 || bus32.in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle: v=%b r=%b, need 0 1", bus32.out_valid_o, bus32.in_ready_o);
    end
  endtask

  task automatic test_async_reset();
    fill_two();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus32.out_valid_o !== 1'b0 || bus32.in_ready_o !== 1'b1 ||
        bus32.imm_o !== 32'h0 || bus32.fmt_o !== 3'd0 ||
        bus32.illegal_o !== 1'b0 || bus32.tag_o !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: v=%b r=%b imm=%h fmt=%0d ill=%b tag=%h, need 0 1 0 0 0 0",
               bus32.out_valid_o, bus32.in_ready_o, bus32.imm_o, bus32.fmt_o,
               bus32.illegal_o, bus32.tag_o);
    end
    #3;
    rst_n = 1'b1;
    bus32.out_ready_i = 1'b1;
    tick();
    n_tests++;
    if (bus32.out_valid_o !== 1'b0 || bus32.in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: v=%b r=%b, need 0 1", bus32.out_valid_o, bus32.in_ready_o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_decode32();
    test_decode64();
    test_back_pressure();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. Accepts one 32-bit instruction per cycle over a valid/ready handshake, then emits the sign- or zero-extended immediate at XLEN width, a format code, and an illegal-opcode flag. A 2-entry skid buffer registers the output and absorbs back-pressure from the execute stage. A TAG_W sideband (PC/ROB tag) travels alongside each instruction unchanged.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
TAG_W, 32, sideband width carried alongside each instruction

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous flush; empties buffer
in_valid_i  in  1  instruction valid
in_ready_o  out  1  block can accept
inst_i  in  32  instruction word
tag_i  in  TAG_W  sideband in
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts
imm_o  out  XLEN  extended immediate
fmt_o  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 Z
illegal_o  out  1  opcode not recognised
tag_o  out  TAG_W  sideband out

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: out_valid_o=0, in_ready_o=1, imm_o=0, fmt_o=0, illegal_o=0, tag_o=0. Both buffer entries are invalid after reset.
- Decode uses opcode inst_i[6:0]. The MSB is inst_i[31]; sign extension goes to XLEN.
- OP-IMM 0010011, LOAD 0000011, JALR 1100111 -> I-format: sext(inst[31:20]).
- OP-IMM with funct3 001 or 101 -> SHAMT: zero-extended shift amount.
  - XLEN=32: inst[24:20].
  - XLEN=64: inst[25:20].
- STORE 0100011 -> S-format: sext({inst[31:25],inst[11:7]}).
- BRANCH 1100011 -> B-format: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
- LUI 0110111, AUIPC 0010111 -> U-format: sext({inst[31:12],12'b0}). At XLEN=64, bits 63:32 copy inst[31].
- JAL 1101111 -> J-format: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
- OP 0110011 -> NONE, imm=0.
- XLEN=64 only: OP-IMM-32 0011011 follows the OP-IMM rules, with a 5-bit shamt; OP-32 0111011 -> NONE.
- Any other opcode -> fmt NONE, imm=0, illegal_o=1. This includes SYSTEM when CSR support is compiled out.
- Latency: exactly 1 cycle from the accepting edge to out_valid_o, when the buffer is empty.
- Handshake rules:
  - Transfer in on in_valid_i & in_ready_o.
  - Transfer out on out_valid_o & out_ready_i.
  - in_ready_o is a registered signal: 1 when fewer than 2 entries are held. It does not depend combinationally on out_ready_i.
- Buffer states: EMPTY, ONE, FULL. Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept, no drain -> FULL.
  - ONE + drain, no accept -> EMPTY.
  - ONE + accept + drain -> ONE (the new entry replaces the old).
  - FULL + drain -> ONE; accept is impossible in FULL.
- Ordering: strict FIFO. The head entry always drives the outputs.
- Output stability: while out_valid_o=1 and out_ready_i=0, all outputs hold stable.
- flush_i: on the next edge both entries are invalidated, out_valid_o=0 and in_ready_o=1. An instruction presented in the same cycle as flush_i is dropped. flush_i has priority over accept and drain.
- Reset asserted mid-operation: the state returns immediately to the reset values and the held entries are lost.

Optional Feature:
Macro IMM_GEN_CSR_EN.
- Defined: SYSTEM 1110011 is decoded.
  - funct3 101, 110, 111 -> fmt Z, imm = zero-extended inst[19:15] (uimm).
  - funct3 001, 010, 011 -> fmt I, imm = sext(inst[31:20]) (CSR address).
  - funct3 000 (ECALL/EBREAK/xRET) -> fmt NONE, imm=0, not illegal.
- Undefined: SYSTEM is flagged illegal_o=1 with imm=0, and fmt code 7 never appears.

Test Plan:
- XLEN=32, out_ready_i=1, addi 0xFFF00093 -> one cycle later imm_o=0xFFFFFFFF, fmt I, illegal_o=0.
- sw 0xFE112E23 -> imm_o=0xFFFFFFFC, fmt S. Then beq 0xFE000CE3 -> imm_o=0xFFFFFFF8, fmt B. Then slli 0x00509093 -> imm_o=5, fmt SHAMT.
- XLEN=64: lui 0x800000B7 -> imm_o=0xFFFFFFFF80000000, fmt U. Then jal 0x0080006F -> imm_o=8, fmt J.
- Back-pressure sequence:
  - Stimulus: out_ready_i=0 while 3 back-to-back valid instructions are offered.
  - Expected while stalled: exactly 2 are accepted, in_ready_o=0 from the cycle after the second accept, and outputs stay stable.
  - Then raise out_ready_i -> all 3 results emerge in order with matching tag_o and none are lost.
- Unknown opcode 0x0000007F -> illegal_o=1, imm_o=0, fmt NONE. csrrwi 0x0052D073:
  - With IMM_GEN_CSR_EN: imm_o=5, fmt Z.
  - Without it: illegal_o=1.
- Buffer holding 2 entries:
  - Assert flush_i for 1 cycle -> next cycle out_valid_o=0, in_ready_o=1.
  - Repeat the fill, then pulse rst_n_i low asynchronously between edges -> outputs immediately take their reset values.
